// File: rtl/execute_stage_if.sv
// Bundle between the register-read stage, the EX stage and the EX/MEM pipeline register.
// The master side drives the operands and opcode; the slave side (execute_stage) returns the registered results.
interface execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int IDX_W  = 5,
  parameter int IMM_W  = 7
);
  logic [OP_W-1:0]   control_in;
  logic [IDX_W-1:0]  dest_index_in;
  logic [DATA_W-1:0] reg1_data;
  logic [DATA_W-1:0] reg2_data;
  logic [DATA_W-1:0] npc;
  logic [IMM_W-1:0]  immediate;

  logic [IDX_W-1:0]  dest_index_out;
  logic [OP_W-1:0]   control_out;
  logic [DATA_W-1:0] output_reg;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] target;
  logic              DEST_REG_WRITE_EN;
  logic              ZF;
  logic              GF;
  logic              LF;

  modport master (
    output control_in, dest_index_in, reg1_data, reg2_data, npc, immediate,
    input  dest_index_out, control_out, output_reg, result_out, target,
           DEST_REG_WRITE_EN, ZF, GF, LF
  );

  modport slave (
    input  control_in, dest_index_in, reg1_data, reg2_data, npc, immediate,
    output dest_index_out, control_out, output_reg, result_out, target,
           DEST_REG_WRITE_EN, ZF, GF, LF
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage of the 16-bit pipelined CPU: ALU, branch target and compare flags into the EX/MEM register.
// Optional EXECUTE_SAT_ARITH_EN: SUB/ADD/ADDI saturate on signed overflow instead of wrapping.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int IDX_W  = 5,
  parameter int IMM_W  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  execute_stage_if.slave ex
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(13);

  // Add/sub for the arithmetic ops; overflow is detected from operand and result signs.
  function automatic logic [DATA_W-1:0] arith(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sub
  );
    logic signed [DATA_W-1:0] w;
    logic                     ovf;
    w   = sub ? (a - b) : (a + b);
    ovf = sub ? ((a[DATA_W-1] != b[DATA_W-1]) && (w[DATA_W-1] != a[DATA_W-1]))
              : ((a[DATA_W-1] == b[DATA_W-1]) && (w[DATA_W-1] != a[DATA_W-1]));
`ifdef EXECUTE_SAT_ARITH_EN
    if (ovf)
      return a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return w;
`else
    return ovf ? w : w;
`endif
  endfunction

  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic signed [DATA_W-1:0] cmp_b_p0;
  logic        [DATA_W-1:0] res_p0;
  logic        [DATA_W-1:0] target_p0;
  logic        [SH_W-1:0]   sh_p0;
  logic                     we_p0;
  logic                     upd_p0;

  // Stage p0: combinational execute on the operands presented by decode
  always_comb begin
    a_p0      = ex.reg1_data;
    b_p0      = ex.reg2_data;
    imm_p0    = {{(DATA_W-IMM_W){ex.immediate[IMM_W-1]}}, ex.immediate};
    sh_p0     = ex.reg2_data[SH_W-1:0];
    cmp_b_p0  = b_p0;
    res_p0    = '0;
    we_p0     = 1'b0;
    upd_p0    = 1'b0;
    target_p0 = ex.npc + imm_p0;
    case (ex.control_in)
      OP_SUB:  begin res_p0 = arith(a_p0, b_p0, 1'b1);   we_p0 = 1'b1; upd_p0 = 1'b1; end
      OP_ADD:  begin res_p0 = arith(a_p0, b_p0, 1'b0);   we_p0 = 1'b1; upd_p0 = 1'b1; end
      OP_ADDI: begin
        res_p0   = arith(a_p0, imm_p0, 1'b0);
        cmp_b_p0 = imm_p0;
        we_p0    = 1'b1;
        upd_p0   = 1'b1;
      end
      OP_AND:  begin res_p0 = a_p0 & b_p0;     we_p0 = 1'b1; end
      OP_OR:   begin res_p0 = a_p0 | b_p0;     we_p0 = 1'b1; end
      OP_XOR:  begin res_p0 = a_p0 ^ b_p0;     we_p0 = 1'b1; end
      OP_NOT:  begin res_p0 = ~a_p0;           we_p0 = 1'b1; end
      OP_SLL:  begin res_p0 = a_p0 << sh_p0;   we_p0 = 1'b1; end
      OP_SRL:  begin res_p0 = ex.reg1_data >> sh_p0; we_p0 = 1'b1; end
      OP_SRA:  begin res_p0 = a_p0 >>> sh_p0;  we_p0 = 1'b1; end
      OP_CMP:  upd_p0 = 1'b1;
      OP_LD:   begin res_p0 = a_p0 + imm_p0;   we_p0 = 1'b1; end
      OP_ST:   res_p0 = a_p0 + imm_p0;
      default: ;
    endcase
  end

  // Stage p1: EX/MEM pipeline register; flags hold unless a flag-updating op is in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.dest_index_out    <= '0;
      ex.control_out       <= '0;
      ex.output_reg        <= '0;
      ex.result_out        <= '0;
      ex.target            <= '0;
      ex.DEST_REG_WRITE_EN <= 1'b0;
      ex.ZF                <= 1'b0;
      ex.GF                <= 1'b0;
      ex.LF                <= 1'b0;
    end else begin
      ex.dest_index_out    <= ex.dest_index_in;
      ex.control_out       <= ex.control_in;
      ex.output_reg        <= ex.reg2_data;
      ex.result_out        <= res_p0;
      ex.target            <= target_p0;
      ex.DEST_REG_WRITE_EN <= we_p0;
      if (upd_p0) begin
        ex.ZF <= (a_p0 == cmp_b_p0);
        ex.GF <= (a_p0 >  cmp_b_p0);
        ex.LF <= (a_p0 <  cmp_b_p0);
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases, flag hold, randomized ops against an
// integer-arithmetic reference model, and asynchronous reset in mid-stream.
module tb_execute_stage;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  execute_stage_if #(.DATA_W(16), .OP_W(5), .IDX_W(5), .IMM_W(7)) ex_bus ();

  execute_stage #(.DATA_W(16), .OP_W(5), .IDX_W(5), .IMM_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference flag state
  logic mzf, mgf, mlf;

  function automatic int clamp(input int v);
`ifdef EXECUTE_SAT_ARITH_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [6:0] im, output logic [15:0] res,
                                output logic we, output logic upd, output int cb);
    int sa, sb, si, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    si = int'($signed(im));
    r = 0; we = 1'b0; upd = 1'b0; cb = sb;
    case (op)
      5'd1:  begin r = clamp(sa - sb); we = 1'b1; upd = 1'b1; end
      5'd2:  begin r = clamp(sa + sb); we = 1'b1; upd = 1'b1; end
      5'd3:  begin r = clamp(sa + si); we = 1'b1; upd = 1'b1; cb = si; end
      5'd4:  begin r = int'(a & b);  we = 1'b1; end
      5'd5:  begin r = int'(a | b);  we = 1'b1; end
      5'd6:  begin r = int'(a ^ b);  we = 1'b1; end
      5'd7:  begin r = int'(~a);     we = 1'b1; end
      5'd8:  begin r = int'(a) << b[3:0];  we = 1'b1; end
      5'd9:  begin r = int'(a) >> b[3:0];  we = 1'b1; end
      5'd10: begin r = sa >>> b[3:0];      we = 1'b1; end
      5'd11: upd = 1'b1;
      5'd12: begin r = sa + si; we = 1'b1; end
      5'd13: r = sa + si;
      default: ;
    endcase
    res = 16'(r);
  endfunction

  task automatic drive(input logic [4:0] op, input logic [4:0] d, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] n, input logic [6:0] im);
    @(negedge clk);
    ex_bus.control_in    = op;
    ex_bus.dest_index_in = d;
    ex_bus.reg1_data     = a;
    ex_bus.reg2_data     = b;
    ex_bus.npc           = n;
    ex_bus.immediate     = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd2, 5'd9, 16'h1234, 16'h1111, 16'h0040, 7'h05);
    tick();
    tests++;
    if ({ex_bus.dest_index_out, ex_bus.control_out, ex_bus.output_reg, ex_bus.result_out,
         ex_bus.target, ex_bus.DEST_REG_WRITE_EN, ex_bus.ZF, ex_bus.GF, ex_bus.LF} !== 62'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ctrl=%h res=%h tgt=%h we=%b flags=%b%b%b, required all 0",
               ex_bus.control_out, ex_bus.result_out, ex_bus.target, ex_bus.DEST_REG_WRITE_EN,
               ex_bus.ZF, ex_bus.GF, ex_bus.LF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mzf = 1'b0; mgf = 1'b0; mlf = 1'b0;
  endtask

  task automatic test_directed();
    drive(5'd1, 5'd2, 16'd10, 16'd3, 16'h0000, 7'h00);
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.ZF, ex_bus.GF, ex_bus.LF}
        !== {16'd7, 1'b1, 5'd2, 3'b010}) begin
      fails++;
      $display("FAIL sub_basic: got res=%h we=%b dest=%0d zgl=%b%b%b, required res=0007 we=1 dest=2 zgl=010",
               ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.ZF, ex_bus.GF, ex_bus.LF);
    end
    drive(5'd2, 5'd3, 16'd10, 16'd5, 16'h0000, 7'h00);
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN} !== {16'd15, 1'b1}) begin
      fails++;
      $display("FAIL add_basic: got res=%h we=%b, required res=000f we=1", ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN);
    end
    drive(5'd3, 5'd4, 16'd10, 16'hFFFF, 16'h0000, 7'd7);
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.output_reg} !== {16'd17, 1'b1, 16'hFFFF}) begin
      fails++;
      $display("FAIL addi_basic: got res=%h we=%b oreg=%h, required res=0011 we=1 oreg=ffff",
               ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.output_reg);
    end
    drive(5'd2, 5'd5, 16'h7FFF, 16'h0001, 16'h0000, 7'h00);
    tick();
    tests++;
`ifdef EXECUTE_SAT_ARITH_EN
    if (ex_bus.result_out !== 16'h7FFF) begin
      fails++;
      $display("FAIL add_overflow: got %h, required 7fff", ex_bus.result_out);
    end
`else
    if (ex_bus.result_out !== 16'h8000) begin
      fails++;
      $display("FAIL add_overflow: got %h, required 8000", ex_bus.result_out);
    end
`endif
    drive(5'd15, 5'd6, 16'h0000, 16'h0000, 16'h0010, 7'h7E);
    tick();
    tests++;
    if ({ex_bus.target, ex_bus.DEST_REG_WRITE_EN, ex_bus.result_out, ex_bus.control_out}
        !== {16'h000E, 1'b0, 16'h0000, 5'd15}) begin
      fails++;
      $display("FAIL beq_target: got tgt=%h we=%b res=%h ctrl=%h, required tgt=000e we=0 res=0000 ctrl=0f",
               ex_bus.target, ex_bus.DEST_REG_WRITE_EN, ex_bus.result_out, ex_bus.control_out);
    end
    drive(5'd13, 5'd7, 16'h0100, 16'hBEEF, 16'h0000, 7'd4);
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.output_reg, ex_bus.DEST_REG_WRITE_EN} !== {16'h0104, 16'hBEEF, 1'b0}) begin
      fails++;
      $display("FAIL st_address: got res=%h oreg=%h we=%b, required res=0104 oreg=beef we=0",
               ex_bus.result_out, ex_bus.output_reg, ex_bus.DEST_REG_WRITE_EN);
    end
    drive(5'd0, 5'd17, 16'hAAAA, 16'h5555, 16'h0002, 7'h01);
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.control_out, ex_bus.target}
        !== {16'h0000, 1'b0, 5'd17, 5'd0, 16'h0003}) begin
      fails++;
      $display("FAIL nop_passthru: got res=%h we=%b dest=%0d ctrl=%h tgt=%h, required res=0 we=0 dest=17 ctrl=0 tgt=0003",
               ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.control_out, ex_bus.target);
    end
  endtask

  task automatic test_flag_hold();
    drive(5'd11, 5'd1, 16'h0042, 16'h0042, 16'h0000, 7'h00);
    tick();
    tests++;
    if ({ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.DEST_REG_WRITE_EN} !== 4'b1000) begin
      fails++;
      $display("FAIL cmp_equal: got zgl=%b%b%b we=%b, required zgl=100 we=0",
               ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.DEST_REG_WRITE_EN);
    end
    drive(5'd4, 5'd1, 16'h0001, 16'h0F00, 16'h0000, 7'h00);
    tick();
    tests++;
    if ({ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.result_out} !== {3'b100, 16'h0000}) begin
      fails++;
      $display("FAIL and_holds_flags: got zgl=%b%b%b res=%h, required zgl=100 res=0000",
               ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.result_out);
    end
    drive(5'd11, 5'd1, 16'hFFFE, 16'h0003, 16'h0000, 7'h00);
    tick();
    tests++;
    if ({ex_bus.ZF, ex_bus.GF, ex_bus.LF} !== 3'b001) begin
      fails++;
      $display("FAIL cmp_signed_less: got zgl=%b%b%b, required 001", ex_bus.ZF, ex_bus.GF, ex_bus.LF);
    end
    drive(5'd3, 5'd1, 16'h0000, 16'h0000, 16'h0000, 7'h7F);
    tick();
    tests++;
    if ({ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.result_out} !== {3'b010, 16'hFFFF}) begin
      fails++;
      $display("FAIL addi_flags_vs_imm: got zgl=%b%b%b res=%h, required zgl=010 res=ffff",
               ex_bus.ZF, ex_bus.GF, ex_bus.LF, ex_bus.result_out);
    end
    mzf = 1'b0; mgf = 1'b1; mlf = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  op, d;
    logic [15:0] a, b, n, eres, etgt;
    logic [6:0]  im;
    logic        ewe, eupd;
    int          cb, sa;
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      d  = 5'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      n  = 16'($urandom);
      im = 7'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        2: b = a;
        default: ;
      endcase
      model(op, a, b, im, eres, ewe, eupd, cb);
      sa   = int'($signed(a));
      etgt = 16'(int'(n) + int'($signed(im)));
      if (eupd) begin
        mzf = (sa == cb);
        mgf = (sa > cb);
        mlf = (sa < cb);
      end
      drive(op, d, a, b, n, im);
      tick();
      tests++;
      if (ex_bus.result_out !== eres) begin
        fails++;
        $display("FAIL rand_result #%0d op=%0d a=%h b=%h imm=%h: got %h, required %h",
                 i, op, a, b, im, ex_bus.result_out, eres);
      end
      tests++;
      if ({ex_bus.dest_index_out, ex_bus.control_out, ex_bus.output_reg, ex_bus.target,
           ex_bus.DEST_REG_WRITE_EN, ex_bus.ZF, ex_bus.GF, ex_bus.LF}
          !== {d, op, b, etgt, ewe, mzf, mgf, mlf}) begin
        fails++;
        $display("FAIL rand_ctrl #%0d op=%0d: got dest=%0d ctrl=%0d oreg=%h tgt=%h we=%b zgl=%b%b%b, required dest=%0d ctrl=%0d oreg=%h tgt=%h we=%b zgl=%b%b%b",
                 i, op, ex_bus.dest_index_out, ex_bus.control_out, ex_bus.output_reg, ex_bus.target,
                 ex_bus.DEST_REG_WRITE_EN, ex_bus.ZF, ex_bus.GF, ex_bus.LF,
                 d, op, b, etgt, ewe, mzf, mgf, mlf);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(5'd2, 5'd12, 16'h1000, 16'h2000, 16'h0100, 7'h10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ex_bus.dest_index_out, ex_bus.control_out, ex_bus.output_reg, ex_bus.result_out,
         ex_bus.target, ex_bus.DEST_REG_WRITE_EN, ex_bus.ZF, ex_bus.GF, ex_bus.LF} !== 62'd0) begin
      fails++;
      $display("FAIL async_reset_clear: got dest=%0d ctrl=%h res=%h tgt=%h we=%b zgl=%b%b%b, required all 0",
               ex_bus.dest_index_out, ex_bus.control_out, ex_bus.result_out, ex_bus.target,
               ex_bus.DEST_REG_WRITE_EN, ex_bus.ZF, ex_bus.GF, ex_bus.LF);
    end
    drive(5'd2, 5'd3, 16'd1, 16'd1, 16'h0000, 7'h00);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.ZF, ex_bus.GF, ex_bus.LF}
        !== {16'd2, 1'b1, 5'd3, 3'b100}) begin
      fails++;
      $display("FAIL after_release_add: got res=%h we=%b dest=%0d zgl=%b%b%b, required res=0002 we=1 dest=3 zgl=100",
               ex_bus.result_out, ex_bus.DEST_REG_WRITE_EN, ex_bus.dest_index_out, ex_bus.ZF, ex_bus.GF, ex_bus.LF);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ex_bus.control_in    = '0;
    ex_bus.dest_index_in = '0;
    ex_bus.reg1_data     = '0;
    ex_bus.reg2_data     = '0;
    ex_bus.npc           = '0;
    ex_bus.immediate     = '0;
    test_reset();
    test_directed();
    test_flag_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
